// File: rtl/fan_pkg.sv
// Shared types, limits and counter sizing helper for the fan PWM controller.
package fan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KICK = 2'd1,
        RUN  = 2'd2
    } fan_state_e;

    typedef logic [3:0] fan_duty_t;

    localparam fan_duty_t FanDutyMax = 4'd15;

    // Counter width for a count that runs 0..limit-1; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/fan_sw_debounce.sv
// Fan switch synchroniser and debouncer: a new level is accepted after DebounceCycles
// consecutive equal synced samples; change_o pulses for one cycle on acceptance.
module fan_sw_debounce
    import fan_pkg::*;
#(
    parameter int DebounceCycles = 500_000
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  fan_duty_t sw_i,
    output fan_duty_t target_o,
    output logic      chg_o
);

    localparam int DbW = cnt_width(DebounceCycles);

    fan_duty_t      sync1_q, sync2_q, last_q;
    fan_duty_t      target_q, target_d;
    logic [DbW-1:0] cnt_q, cnt_d;
    logic           chg_q, chg_d;
    int             run;

    // run = length of the current streak of equal synced samples, this one included
    always_comb begin
        run      = (sync2_q != last_q) ? 1 : int'(cnt_q) + 1;
        cnt_d    = cnt_q;
        target_d = target_q;
        chg_d    = 1'b0;
        if (sync2_q == target_q) begin
            cnt_d = '0;
        end else if (run >= DebounceCycles) begin
            target_d = sync2_q;
            chg_d    = 1'b1;
            cnt_d    = '0;
        end else begin
            cnt_d = DbW'(run);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            last_q   <= '0;
            target_q <= '0;
            cnt_q    <= '0;
            chg_q    <= 1'b0;
        end else begin
            sync1_q  <= sw_i;
            sync2_q  <= sync1_q;
            last_q   <= sync2_q;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            chg_q    <= chg_d;
        end
    end

    assign target_o = target_q;
    assign chg_o    = chg_q;

endmodule

// File: rtl/fan_pwm_ramp.sv
// Fan PWM controller: debounced switch target, 100% kick-start from stop, stepped duty ramp.
// Define FAN_TACH_EN to build the tach edge counter and stall detector.
//  state | meaning
//  IDLE  | fan off, waiting for a nonzero target at a period boundary
//  KICK  | full duty for KickPeriods PWM periods to spin the fan up
//  RUN   | duty moves one level per RampPeriods periods toward target
module fan_pwm_ramp
    import fan_pkg::*;
#(
    parameter int ClkFreqHz        = 50_000_000,
    parameter int PwmFreqHz        = 25_000,
    parameter int DebounceCycles   = 500_000,
    parameter int KickPeriods      = 250,
    parameter int RampPeriods      = 50,
    parameter int TachWindowCycles = 50_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  fan_sw_i,
    input  logic        fan_tach_i,
    output logic        fan_pwm_o,
    output logic [3:0]  duty_o,
    output logic        kick_o,
    output logic [15:0] tach_cnt_o,
    output logic        stall_o
);

    localparam int PeriodCycles = ClkFreqHz / PwmFreqHz;
    localparam int StepCycles   = PeriodCycles / 15;
    localparam int PcW          = cnt_width(PeriodCycles);
    localparam int KcW          = cnt_width(KickPeriods);
    localparam int RcW          = cnt_width(RampPeriods);

    fan_state_e     state_q, state_d;
    fan_duty_t      duty_q, duty_d;
    fan_duty_t      target;
    logic           tgt_chg;
    logic [PcW-1:0] pcnt_q, pcnt_d, thr;
    logic [KcW-1:0] kick_cnt_q, kick_cnt_d;
    logic [RcW-1:0] ramp_cnt_q, ramp_cnt_d;
    logic           boundary;
    logic           pwm_q, pwm_d;

    fan_sw_debounce #(
        .DebounceCycles(DebounceCycles)
    ) u_debounce (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .sw_i    (fan_sw_i),
        .target_o(target),
        .chg_o   (tgt_chg)
    );

    assign boundary = (pcnt_q == PcW'(PeriodCycles - 1));
    assign pcnt_d   = boundary ? '0 : pcnt_q + PcW'(1);
    assign thr      = PcW'(int'(duty_q) * StepCycles);

    always_comb begin
        state_d    = state_q;
        duty_d     = duty_q;
        kick_cnt_d = kick_cnt_q;
        ramp_cnt_d = ramp_cnt_q;
        if (boundary) begin
            case (state_q)
                IDLE: begin
                    duty_d = '0;
                    if (target != '0) begin
                        state_d    = KICK;
                        kick_cnt_d = '0;
                    end
                end
                KICK: begin
                    if (target == '0) begin
                        state_d = IDLE;
                    end else if (kick_cnt_q == KcW'(KickPeriods - 1)) begin
                        state_d    = RUN;
                        duty_d     = target;
                        ramp_cnt_d = '0;
                    end else begin
                        kick_cnt_d = kick_cnt_q + KcW'(1);
                    end
                end
                RUN: begin
                    if (duty_q == target) begin
                        ramp_cnt_d = '0;
                    end else if (ramp_cnt_q == RcW'(RampPeriods - 1)) begin
                        ramp_cnt_d = '0;
                        if (duty_q < target) begin
                            duty_d = duty_q + 4'd1;
                        end else begin
                            duty_d = duty_q - 4'd1;
                            if (duty_q == 4'd1) state_d = IDLE;
                        end
                    end else begin
                        ramp_cnt_d = ramp_cnt_q + RcW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    duty_d  = '0;
                end
            endcase
        end
        // A freshly accepted target always gets a full ramp interval before the first step
        if (tgt_chg) ramp_cnt_d = '0;
    end

    always_comb begin
        pwm_d = 1'b0;
        if (state_q == KICK || duty_q == FanDutyMax) begin
            pwm_d = 1'b1;
        end else if (duty_q != '0) begin
            pwm_d = (pcnt_q < thr);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            duty_q     <= '0;
            pcnt_q     <= '0;
            kick_cnt_q <= '0;
            ramp_cnt_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            pcnt_q     <= pcnt_d;
            kick_cnt_q <= kick_cnt_d;
            ramp_cnt_q <= ramp_cnt_d;
            pwm_q      <= pwm_d;
        end
    end

    assign fan_pwm_o = pwm_q;
    assign duty_o    = duty_q;
    assign kick_o    = (state_q == KICK);

`ifdef FAN_TACH_EN
    localparam int TwW = cnt_width(TachWindowCycles);

    logic           tsync1_q, tsync2_q, tprev_q, tach_rise;
    logic [15:0]    tcnt_q, tcnt_d, tlat_q, tlat_d;
    logic [TwW-1:0] win_q, win_d;
    logic           win_end;
    logic           stall_q, stall_d;

    assign tach_rise = tsync2_q & ~tprev_q;
    assign win_end   = (win_q == TwW'(TachWindowCycles - 1));
    assign win_d     = win_end ? '0 : win_q + TwW'(1);

    // A rise landing on the window's last cycle is credited to the next window
    always_comb begin
        tcnt_d  = tcnt_q;
        tlat_d  = tlat_q;
        stall_d = stall_q;
        if (win_end) begin
            tlat_d = tcnt_q;
            tcnt_d = {15'd0, tach_rise};
        end else if (tach_rise && tcnt_q != 16'hFFFF) begin
            tcnt_d = tcnt_q + 16'd1;
        end
        if (state_q != RUN) begin
            stall_d = 1'b0;
        end else if (win_end) begin
            stall_d = (tcnt_q == 16'd0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tsync1_q <= 1'b0;
            tsync2_q <= 1'b0;
            tprev_q  <= 1'b0;
            tcnt_q   <= '0;
            tlat_q   <= '0;
            win_q    <= '0;
            stall_q  <= 1'b0;
        end else begin
            tsync1_q <= fan_tach_i;
            tsync2_q <= tsync1_q;
            tprev_q  <= tsync2_q;
            tcnt_q   <= tcnt_d;
            tlat_q   <= tlat_d;
            win_q    <= win_d;
            stall_q  <= stall_d;
        end
    end

    assign tach_cnt_o = tlat_q;
    assign stall_o    = stall_q;
`else
    localparam int unused_tach_window = TachWindowCycles;
    logic unused_tach;

    assign unused_tach = fan_tach_i;
    assign tach_cnt_o  = '0;
    assign stall_o     = 1'b0;
`endif

endmodule
